// File: rtl/memory_fill_responder_pkg.sv
// Shared constants and request decoding for the cache-fill memory responder.
// The arbiter and the cache fill controllers use the same constants.
package memory_fill_responder_pkg;

  localparam int MEM_LATENCY = 4;
  localparam int MEM_DATA_W  = 16;
  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_DEPTH   = 32768;
  localparam int BLOCK_WORDS = 8;
  localparam int PEND_W      = 4;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_READ,
    REQ_WRITE
  } req_e;

  function automatic req_e decode_req(input logic enable, input logic wr);
    if (!enable) return REQ_NONE;
    return wr ? REQ_WRITE : REQ_READ;
  endfunction

  // A new read and a returning read in the same cycle cancel out.
  function automatic logic [PEND_W-1:0] pending_next(input logic [PEND_W-1:0] cnt,
                                                     input logic inc,
                                                     input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + 1'b1;
      2'b01:   return cnt - 1'b1;
      default: return cnt;
    endcase
  endfunction

endpackage

// File: rtl/memory_fill_responder_pipe.sv
// Fixed-depth {valid, data} return pipeline. It shifts every cycle with no stall.
// Only the valid bits are reset; data is masked at the output while invalid.
module memory_fill_responder_pipe
  import memory_fill_responder_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int LATENCY    = MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [LATENCY];

  always_comb begin
    vld_d[0] = in_vld;
    dat_d[0] = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign out_vld  = vld_q[LATENCY-1];
  assign out_data = out_vld ? dat_q[LATENCY-1] : '0;

endmodule

// File: rtl/memory_fill_responder.sv
// Memory responder for cache fills. It accepts one read or write per cycle and
// returns each read word a fixed LATENCY cycles later, in order.
module memory_fill_responder
  import memory_fill_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int LATENCY    = MEM_LATENCY,
  parameter int MEM_WORDS  = MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [PEND_W-1:0]     pending
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_acc, wr_acc;
  logic [PEND_W-1:0]     pending_q, pending_d;
  req_e                  req;

  // The byte address becomes a word index that wraps at the array depth.
  assign idx     = IDX_W'((addr >> 1) % MEM_WORDS);
  assign req     = decode_req(enable, wr);
  assign rd_acc  = (req == REQ_READ);
  assign wr_acc  = (req == REQ_WRITE);
  // The read word is captured into the pipe on the accept edge, so later writes cannot change it.
  assign rd_word = mem[idx];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[idx] <= data_in;
  end

  memory_fill_responder_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc),
    .in_data  (rd_word),
    .out_vld  (data_valid),
    .out_data (data_out)
  );

  always_comb begin
    pending_d = pending_next(pending_q, rd_acc, data_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

  assert property (@(posedge clk) disable iff (rst) !$isunknown(enable));

endmodule
